// File: rtl/sawtooth_analyzer.sv
// Sawtooth receiver: detects ramp wraps and reports period, peak and trough per period. Result 1 cycle after wrap sample.
// No backpressure on samples; unconsumed result blocks newer ones (dropped, sticky overrun). Option: SAWTOOTH_ANALYZER_TIMEOUT_EN.
module sawtooth_analyzer #(
   parameter int SAMPLE_WIDTH   = 8,
   parameter int PERIOD_WIDTH   = 16,
   parameter int DROP_THRESHOLD = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   input  logic                    sample_valid,
   output logic [PERIOD_WIDTH-1:0] period_out,
   output logic [SAMPLE_WIDTH-1:0] peak_out,
   output logic [SAMPLE_WIDTH-1:0] trough_out,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic                    locked,
   output logic                    overrun
);

   typedef enum logic [1:0] {IDLE, SEEK, MEASURE} state_t;

   localparam logic [SAMPLE_WIDTH:0]   THRESH  = (SAMPLE_WIDTH+1)'(DROP_THRESHOLD);
   localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;

   state_t                  state, state_nxt;
   logic [SAMPLE_WIDTH-1:0] prev;
   logic [SAMPLE_WIDTH-1:0] run_max, run_min;
   logic [PERIOD_WIDTH-1:0] count, prev_period, period_diff;
   logic [SAMPLE_WIDTH:0]   step_down;
   logic                    wrap, gen_result, slot_free, load, discard, timeout, in_lock;

   assign step_down  = {1'b0, prev} - {1'b0, sample_in};
   assign wrap       = sample_valid && (prev > sample_in) && (step_down >= THRESH);
   assign gen_result = (state == MEASURE) && wrap;
   assign slot_free  = !result_valid || result_ready;
   assign load       = gen_result && slot_free;
   assign discard    = gen_result && !slot_free;

   assign period_diff = (count >= prev_period) ? (count - prev_period) : (prev_period - count);
   assign in_lock     = (period_diff <= PERIOD_WIDTH'(1));

`ifdef SAWTOOTH_ANALYZER_TIMEOUT_EN
   // Abandon a period the moment the counter would hit all-ones.
   assign timeout = (state == MEASURE) && sample_valid && !wrap &&
                    (count == CNT_MAX - PERIOD_WIDTH'(1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sample_valid) state_nxt = SEEK;
         SEEK:    if (wrap)         state_nxt = MEASURE;
         MEASURE: if (timeout)      state_nxt = SEEK;
         default:                   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev         <= '0;
         count        <= '0;
         run_max      <= '0;
         run_min      <= '0;
         prev_period  <= '0;
         period_out   <= '0;
         peak_out     <= '0;
         trough_out   <= '0;
         result_valid <= 1'b0;
         locked       <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (sample_valid) prev <= sample_in;

         // The wrap sample opens the new period.
         if (wrap && state != IDLE) begin
            count   <= PERIOD_WIDTH'(1);
            run_max <= sample_in;
            run_min <= sample_in;
         end else if (timeout) begin
            count <= '0;
         end else if (sample_valid && state == MEASURE) begin
            if (count != CNT_MAX) count <= count + PERIOD_WIDTH'(1);
            if (sample_in > run_max) run_max <= sample_in;
            if (sample_in < run_min) run_min <= sample_in;
         end

         if (load) begin
            period_out   <= count;
            peak_out     <= run_max;
            trough_out   <= run_min;
            result_valid <= 1'b1;
            locked       <= in_lock;
         end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
         end

         if (gen_result) prev_period <= count;
         if (discard)    overrun     <= 1'b1;
         if (timeout)    locked      <= 1'b0;
      end
   end

endmodule

// File: doc/sawtooth_analyzer.md
# sawtooth_analyzer

Receive-side counterpart of the sawtooth wave generator: consumes an 8-bit sample stream with a valid strobe and measures the waveform. It detects each ramp wrap (large downward step) and reports period in samples, peak and trough per period through a valid/ready result interface. It sits at the capture end of the audio path and closes the loop on generator self-test and frequency-control calibration.

## Interface
- SAMPLE_WIDTH, 8, sample width in bits
- PERIOD_WIDTH, 16, period counter and result width
- DROP_THRESHOLD, 64, minimum downward step (prev − cur) that counts as a wrap
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (low = reset asserted); one clock, no other clock domains
- sample_in  input  SAMPLE_WIDTH  incoming sample, unsigned
- sample_valid  input  1  sample_in is consumed on each rising edge where high; no backpressure to the source
- period_out  output  PERIOD_WIDTH  samples per completed period
- peak_out  output  SAMPLE_WIDTH  maximum sample in the completed period
- trough_out  output  SAMPLE_WIDTH  minimum sample in the completed period
- result_valid  output  1  result registers hold an unconsumed result
- result_ready  input  1  consumer accepts result when high with result_valid
- locked  output  1  last two reported periods differ by at most 1
- overrun  output  1  sticky; a result was discarded because the previous one was not consumed

## Operation
- States: IDLE (no sample yet), SEEK (have previous sample, waiting for first wrap), MEASURE (counting a period).
- Wrap: valid sample with prev > cur and (prev − cur) ≥ DROP_THRESHOLD, unsigned, computed at SAMPLE_WIDTH+1 bits. prev updates on every valid sample.
- IDLE → SEEK on first valid sample. SEEK → MEASURE on first wrap; no result emitted. MEASURE stays MEASURE; each wrap emits a result.
- The wrap sample is the first sample of the new period: on wrap, count ← 1, running max/min ← cur. On a non-wrap valid sample in MEASURE: count +1 (saturating at all-ones), max/min update.
- Result on wrap in MEASURE: period_out ← count, peak_out ← max, trough_out ← min (the completed period, excluding the wrap sample).
- Handshake: transfer when result_valid && result_ready; result_valid clears next edge unless a new result loads in the same edge (then stays 1 with new data).
- Result arriving while result_valid=1 and result_ready=0: new result dropped, held outputs unchanged, overrun ← 1 until reset.
- locked: on each loaded result, locked ← (|period − previous period| ≤ 1); the previous period register updates on every generated result, including dropped ones. Cleared on leaving MEASURE.
- Samples with sample_valid=0 have no effect; gaps do not change period.

## Timing
- Reset (async assert, sync-release assumed by system): state IDLE, count 0, prev 0, all outputs 0.
- Wrap sample consumed at edge N → result_valid=1 and results visible after edge N (first cycle N+1); latency 1 cycle.
- locked updates on the same edge as the result load.
- Reset asserted mid-period: measurement discarded, pending result lost, overrun cleared.
- Count saturates at 2^PERIOD_WIDTH − 1; saturated period is reported as that value.

## Configuration
- SAWTOOTH_ANALYZER_TIMEOUT_EN defined: when count reaches 2^PERIOD_WIDTH − 1 in MEASURE, state → SEEK, locked ← 0, count ← 0; no result emitted; next wrap re-enters MEASURE without a result.
- Not defined: count saturates, state stays MEASURE, next wrap reports period = 2^PERIOD_WIDTH − 1.

## Test plan
- Reset: hold reset low with random sample_in/valid → all outputs 0, no result_valid after release until two wraps occur.
- 16-step ramp 0,16,…,240 repeated, valid every cycle, result_ready=1 → first result after second wrap: period 16, peak 240, trough 0; locked=1 from the second result on.
- Same ramp, valid every 3rd cycle → period 16, result_valid one cycle after each wrap sample.
- result_ready=0 across two wraps → first result (16/240/0) held, overrun=1; raise result_ready → result_valid drops next cycle, overrun stays 1.
- Sequence …,240,200,… (drop 40) → no wrap, period counts through; drop 240→176 (64) → wrap.
- Macro defined, PERIOD_WIDTH=4, constant input for 20 samples after a wrap → state returns to SEEK, locked=0, no result; macro undefined → next wrap reports period 15.
